mem_burst_master: RTL and testbench

Initiator-side controller for the single-port word memory on the CPU data path. It accepts burst read/write requests from a client, converts byte addresses to word indices, and drives the memory's `MEMREAD`/`MEMWRITE`/`ADDR`/`WRITE_DATA` strobes one word per cycle. It captures the memory's registered `READ_DATA` one cycle later and returns it as a response stream. Malformed or out-of-range requests are rejected with an error pulse and never touch memory.

---
 rtl/mem_burst_master_if.sv | 53 +++++
 rtl/mem_burst_master.sv | 157 +++++++++++++++
 tb/tb_mem_burst_master.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_master_if.sv
// ---------------------------------------------------------------------------
// mem_burst_master_if
//
// Groups the client request, write-data, read-response and memory-side
// signals of mem_burst_master into one bundle.
//
//   master modport : the burst controller (drives the memory strobes,
//                    REQ_READY, WR_READY and the response/status pulses)
//   slave modport  : the surrounding environment (client plus memory)
//
// Signals
//   REQ_VALID/REQ_READY/REQ_WRITE/REQ_ADDR/REQ_LEN : burst request
//   WR_VALID/WR_DATA/WR_READY                      : write-data stream
//   RSP_VALID/RSP_DATA/RSP_LAST                    : read-response stream
//   DONE/ERROR                                     : completion / reject pulses
//   MEMREAD/MEMWRITE/ADDR/WRITE_DATA/READ_DATA     : word-memory port
// ---------------------------------------------------------------------------
interface mem_burst_master_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [31:0] REQ_ADDR;
   logic [3:0]  REQ_LEN;
   logic        WR_VALID;
   logic [31:0] WR_DATA;
   logic        WR_READY;
   logic        RSP_VALID;
   logic [31:0] RSP_DATA;
   logic        RSP_LAST;
   logic        DONE;
   logic        ERROR;
   logic        MEMREAD;
   logic        MEMWRITE;
   logic [31:0] ADDR;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;

   modport master (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN,
      input  WR_VALID, WR_DATA, READ_DATA,
      output REQ_READY, WR_READY,
      output RSP_VALID, RSP_DATA, RSP_LAST, DONE, ERROR,
      output MEMREAD, MEMWRITE, ADDR, WRITE_DATA
   );

   modport slave (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN,
      output WR_VALID, WR_DATA, READ_DATA,
      input  REQ_READY, WR_READY,
      input  RSP_VALID, RSP_DATA, RSP_LAST, DONE, ERROR,
      input  MEMREAD, MEMWRITE, ADDR, WRITE_DATA
   );
endinterface

// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
//
// Burst initiator for a single-port word memory. A request (byte address,
// length in words, read/write flag) is accepted in IDLE, validated for one
// cycle in CHECK, then executed one word per cycle in RUN. FINISH carries
// either the DONE pulse or, for a rejected request, the ERROR pulse.
// Read data comes back from the memory one cycle after MEMREAD and is passed
// straight through as the response stream.
//
// Ports
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset, aborts any burst at once
//   bus   : mem_burst_master_if.master (request, write data, response,
//           status pulses and memory port)
//
// Parameters
//   DEPTH_WORDS : number of addressable memory words
//   MAX_BURST   : longest accepted burst in words (must fit REQ_LEN, <= 15)
// ---------------------------------------------------------------------------
module mem_burst_master #(
   parameter int DEPTH_WORDS = 32,
   parameter int MAX_BURST   = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   mem_burst_master_if.master bus
);

   localparam logic [32:0] DEPTH_W33 = 33'(DEPTH_WORDS);
   localparam logic [3:0]  MAX_LEN   = 4'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t      state_reg,   state_next;
   logic [29:0] idx_reg,     idx_next;
   logic [3:0]  len_reg,     len_next;
   logic [3:0]  beat_reg,    beat_next;
   logic        write_reg,   write_next;
   logic [1:0]  addr_lo_reg, addr_lo_next;
   logic        err_reg,     err_next;
   logic        rd_pend_reg;
   logic        rd_last_reg;

   logic [32:0] end_word;
   logic        req_bad;
   logic        last_beat;
   logic [29:0] word_addr;
   logic        mem_read;
   logic        mem_write;

   // End of the burst in 33 bits so a start index near 2^30 cannot wrap
   // around and masquerade as an in-range request.
   assign end_word  = {3'b000, idx_reg} + {29'd0, len_reg};
   assign req_bad   = (addr_lo_reg != 2'b00) || (len_reg == 4'd0) ||
                      (len_reg > MAX_LEN) || (end_word > DEPTH_W33);
   assign last_beat = (beat_reg == (len_reg - 4'd1));
   assign word_addr = idx_reg + {26'd0, beat_reg};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         len_reg     <= '0;
         beat_reg    <= '0;
         write_reg   <= 1'b0;
         addr_lo_reg <= '0;
         err_reg     <= 1'b0;
         rd_pend_reg <= 1'b0;
         rd_last_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         len_reg     <= len_next;
         beat_reg    <= beat_next;
         write_reg   <= write_next;
         addr_lo_reg <= addr_lo_next;
         err_reg     <= err_next;
         // The memory output is registered, so the response for a read
         // strobe appears exactly one cycle later.
         rd_pend_reg <= mem_read;
         rd_last_reg <= mem_read && last_beat;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      len_next     = len_reg;
      beat_next    = beat_reg;
      write_next   = write_reg;
      addr_lo_next = addr_lo_reg;
      err_next     = err_reg;
      mem_read     = 1'b0;
      mem_write    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.REQ_VALID) begin
               write_next   = bus.REQ_WRITE;
               idx_next     = bus.REQ_ADDR[31:2];
               addr_lo_next = bus.REQ_ADDR[1:0];
               len_next     = bus.REQ_LEN;
               beat_next    = 4'd0;
               err_next     = 1'b0;
               state_next   = CHECK;
            end
         end
         CHECK: begin
            err_next   = req_bad;
            state_next = req_bad ? FINISH : RUN;
         end
         RUN: begin
            if (!write_reg) begin
               mem_read  = 1'b1;
               beat_next = beat_reg + 4'd1;
               if (last_beat) begin
                  state_next = FINISH;
               end
            end else if (bus.WR_VALID) begin
               // A missing write word just stalls the beat counter.
               mem_write = 1'b1;
               beat_next = beat_reg + 4'd1;
               if (last_beat) begin
                  state_next = FINISH;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // RESET gates REQ_READY because the state register sits in IDLE while
   // reset is held, yet no request may be taken then.
   assign bus.REQ_READY  = (state_reg == IDLE) && !RESET;
   assign bus.WR_READY   = (state_reg == RUN) && write_reg;
   assign bus.MEMREAD    = mem_read;
   assign bus.MEMWRITE   = mem_write;
   assign bus.ADDR       = (state_reg == RUN) ? {2'b00, word_addr} : 32'd0;
   assign bus.WRITE_DATA = ((state_reg == RUN) && write_reg) ? bus.WR_DATA : 32'd0;
   assign bus.DONE       = (state_reg == FINISH) && !err_reg;
   assign bus.ERROR      = (state_reg == FINISH) && err_reg;
   assign bus.RSP_VALID  = rd_pend_reg;
   assign bus.RSP_LAST   = rd_last_reg;
   assign bus.RSP_DATA   = rd_pend_reg ? bus.READ_DATA : 32'd0;

endmodule

// File: tb/tb_mem_burst_master.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_master
//
// Drives directed and randomized burst requests into mem_burst_master with a
// simple registered word memory attached, and compares every cycle of each
// request against a timeline derived from the request alone (start index,
// length, validity rules and the write-valid pattern).
// ---------------------------------------------------------------------------
module tb_mem_burst_master;
   logic        clk;
   logic        rst;
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] mem_arr [0:31];  // memory attached to the DUT
   logic [31:0] ref_mem [0:31];  // expected memory contents
   bit          pat     [0:63];  // WR_VALID pattern from the first RUN cycle
   logic [31:0] pl      [0:7];   // write payload words

   mem_burst_master_if bus ();

   mem_burst_master #(
      .DEPTH_WORDS (32),
      .MAX_BURST   (8)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory with registered read port.
   always @(posedge clk) begin
      if (bus.MEMWRITE) mem_arr[bus.ADDR[4:0]] <= bus.WRITE_DATA;
      if (bus.MEMREAD)  bus.READ_DATA <= mem_arr[bus.ADDR[4:0]];
   end

   // {REQ_READY, WR_READY, RSP_VALID, RSP_LAST, DONE, ERROR, MEMREAD, MEMWRITE}
   function automatic logic [7:0] ctrl_now();
      return {bus.REQ_READY, bus.WR_READY, bus.RSP_VALID, bus.RSP_LAST,
              bus.DONE, bus.ERROR, bus.MEMREAD, bus.MEMWRITE};
   endfunction

   // One complete request, from the accept cycle (offset 0) until the
   // controller is back in IDLE. Called at 1 ns after a rising edge.
   task automatic run_req(input string name, input bit wr, input logic [31:0] addr,
                          input logic [3:0] len, input bit noise);
      logic [7:0]  e_ctrl [0:63];
      logic [63:0] e_aw   [0:63];
      logic [31:0] e_rd   [0:63];
      bit          d_wv   [0:63];
      logic [31:0] d_wd   [0:63];
      longint      idx;
      int          n;
      int          tend;
      int          cnt;
      int          t;
      bit          ok;
      logic [7:0]  got_ctrl;

      idx = longint'({34'd0, addr[31:2]});
      n   = int'(len);
      ok  = (addr[1:0] == 2'b00) && (n >= 1) && (n <= 8) && (idx + n <= 32);

      // Stimulus plan for the write-data stream.
      for (int i = 0; i < 64; i++) begin
         d_wv[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         d_wd[i] = $urandom;
      end
      if (wr && ok) begin
         cnt = 0;
         for (int i = 2; cnt < n; i++) begin
            d_wv[i] = pat[i - 2];
            if (pat[i - 2]) begin
               d_wd[i] = pl[cnt];
               cnt++;
            end
         end
      end

      // Expected timeline.
      for (int i = 0; i < 64; i++) begin
         e_ctrl[i] = 8'h00;
         e_aw[i]   = 64'd0;
         e_rd[i]   = 32'd0;
      end
      e_ctrl[0] = 8'h80;
      if (!ok) begin
         e_ctrl[2][2] = 1'b1;
         tend = 3;
      end else if (!wr) begin
         for (int k = 0; k < n; k++) begin
            e_ctrl[2 + k][1] = 1'b1;
            e_aw[2 + k]      = {32'(idx + k), 32'd0};
            e_ctrl[3 + k][5] = 1'b1;
            e_rd[3 + k]      = ref_mem[idx + k];
         end
         e_ctrl[n + 2][4] = 1'b1;
         e_ctrl[n + 2][3] = 1'b1;
         tend = n + 3;
      end else begin
         t   = 2;
         cnt = 0;
         while (cnt < n) begin
            e_ctrl[t][6] = 1'b1;
            e_aw[t]      = {32'(idx + cnt), d_wd[t]};
            if (d_wv[t]) begin
               e_ctrl[t][0] = 1'b1;
               cnt++;
            end
            t++;
         end
         e_ctrl[t][3] = 1'b1;
         tend = t + 1;
         for (int k = 0; k < n; k++) ref_mem[idx + k] = pl[k];
      end
      e_ctrl[tend][7] = 1'b1;

      $display("req %s wr=%0d addr=0x%08h len=%0d accept=%0d cycles=%0d",
               name, wr, addr, len, ok, tend + 1);

      for (int tt = 0; tt <= tend; tt++) begin
         if (tt == 0) begin
            bus.REQ_VALID = 1'b1;
            bus.REQ_WRITE = wr;
            bus.REQ_ADDR  = addr;
            bus.REQ_LEN   = len;
         end else if (noise) begin
            // Junk requests while busy must be ignored.
            bus.REQ_VALID = (tt < tend) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.REQ_WRITE = 1'($urandom_range(0, 1));
            bus.REQ_ADDR  = $urandom;
            bus.REQ_LEN   = 4'($urandom_range(0, 15));
         end else begin
            bus.REQ_VALID = 1'b0;
         end
         bus.WR_VALID = d_wv[tt];
         bus.WR_DATA  = d_wd[tt];
         @(negedge clk);
         got_ctrl = ctrl_now();
         n_checks++;
         if (got_ctrl !== e_ctrl[tt]) begin
            n_fail++;
            $display("FAIL %s ctrl at offset %0d: got %b, expected %b (rdy,wrdy,rv,last,done,err,rd,wr)",
                     name, tt, got_ctrl, e_ctrl[tt]);
         end
         n_checks++;
         if ({bus.ADDR, bus.WRITE_DATA} !== e_aw[tt]) begin
            n_fail++;
            $display("FAIL %s addr/wdata at offset %0d: got 0x%08h/0x%08h, expected 0x%08h/0x%08h",
                     name, tt, bus.ADDR, bus.WRITE_DATA, e_aw[tt][63:32], e_aw[tt][31:0]);
         end
         if (e_ctrl[tt][5]) begin
            n_checks++;
            if (bus.RSP_DATA !== e_rd[tt]) begin
               n_fail++;
               $display("FAIL %s rsp_data at offset %0d: got 0x%08h, expected 0x%08h",
                        name, tt, bus.RSP_DATA, e_rd[tt]);
            end
         end
         @(posedge clk);
         #1;
      end
      bus.REQ_VALID = 1'b0;
      bus.WR_VALID  = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.REQ_VALID = 1'b1;
      bus.REQ_WRITE = 1'b1;
      bus.REQ_ADDR  = 32'h10;
      bus.REQ_LEN   = 4'd2;
      bus.WR_VALID  = 1'b1;
      bus.WR_DATA   = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({ctrl_now(), bus.ADDR, bus.WRITE_DATA, bus.RSP_DATA} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset outputs cycle %0d: got ctrl=%b addr=0x%08h wdata=0x%08h rsp=0x%08h, expected all zero",
                     i, ctrl_now(), bus.ADDR, bus.WRITE_DATA, bus.RSP_DATA);
         end
      end
      bus.REQ_VALID = 1'b0;
      rst           = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         bus.WR_VALID = 1'($urandom_range(0, 1));
         bus.WR_DATA  = $urandom;
         @(negedge clk);
         n_checks++;
         if ({ctrl_now(), bus.ADDR, bus.WRITE_DATA} !== {8'h80, 64'd0}) begin
            n_fail++;
            $display("FAIL idle after reset cycle %0d: got ctrl=%b addr=0x%08h wdata=0x%08h, expected ctrl=10000000 and zero bus",
                     i, ctrl_now(), bus.ADDR, bus.WRITE_DATA);
         end
         @(posedge clk);
         #1;
      end
      bus.WR_VALID = 1'b0;
      $display("reset and 10 idle cycles done");
   endtask

   task automatic test_write_burst();
      for (int k = 0; k < 64; k++) pat[k] = 1'b1;
      for (int k = 0; k < 8; k++)  pl[k] = 32'hA0 + 32'(k);
      run_req("write_0x10", 1'b1, 32'h10, 4'd4, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (mem_arr[4 + k] !== 32'hA0 + 32'(k)) begin
            n_fail++;
            $display("FAIL write_0x10 memory word %0d: got 0x%08h, expected 0x%08h",
                     4 + k, mem_arr[4 + k], 32'hA0 + 32'(k));
         end
      end
   endtask

   task automatic test_read_back();
      run_req("read_0x10", 1'b0, 32'h10, 4'd4, 1'b0);
   endtask

   task automatic test_write_gaps();
      for (int k = 0; k < 64; k++) pat[k] = 1'b1;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
      for (int k = 0; k < 8; k++) pl[k] = $urandom;
      run_req("write_gaps", 1'b1, 32'h40, 4'd3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (mem_arr[16 + k] !== pl[k]) begin
            n_fail++;
            $display("FAIL write_gaps memory word %0d: got 0x%08h, expected 0x%08h",
                     16 + k, mem_arr[16 + k], pl[k]);
         end
      end
   endtask

   task automatic test_rejects();
      for (int k = 0; k < 64; k++) pat[k] = 1'b1;
      run_req("rej_misalign", 1'b1, 32'h06,       4'd2, 1'b0);
      run_req("rej_len0",     1'b0, 32'h10,       4'd0, 1'b0);
      run_req("rej_len9",     1'b1, 32'h10,       4'd9, 1'b0);
      run_req("rej_range",    1'b0, 32'h74,       4'd4, 1'b0);
      run_req("rej_wrap",     1'b1, 32'hFFFFFFFC, 4'd4, 1'b0);
   endtask

   task automatic test_preload();
      for (int k = 0; k < 64; k++) pat[k] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 8; k++) pl[k] = $urandom;
         run_req("preload", 1'b1, 32'(b * 32), 4'd8, 1'b0);
      end
   endtask

   task automatic test_boundary();
      run_req("read_top", 1'b0, 32'h70, 4'd4, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [3:0]  len;
      bit          wr;
      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 35)) * 4;
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) addr = $urandom & 32'hFFFF_FFFC;
         len = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
         for (int p = 0; p < 64; p++) pat[p] = (p < 24) ? ($urandom_range(0, 3) != 0) : 1'b1;
         for (int k = 0; k < 8; k++) pl[k] = $urandom;
         run_req("random", wr, addr, len, 1'b1);
      end
   endtask

   task automatic test_reset_mid_burst();
      bus.REQ_VALID = 1'b1;
      bus.REQ_WRITE = 1'b0;
      bus.REQ_ADDR  = 32'h0;
      bus.REQ_LEN   = 4'd8;
      @(posedge clk);
      #1;
      bus.REQ_VALID = 1'b0;
      @(posedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.MEMREAD, bus.ADDR} !== {1'b1, 32'(b)}) begin
            n_fail++;
            $display("FAIL abort beat %0d: got memread=%b addr=0x%08h, expected memread=1 addr=0x%08h",
                     b, bus.MEMREAD, bus.ADDR, 32'(b));
         end
         @(posedge clk);
         #1;
      end
      #1;
      n_checks++;
      if (ctrl_now() !== 8'h22) begin
         n_fail++;
         $display("FAIL abort pre-reset ctrl: got %b, expected 00100010", ctrl_now());
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ctrl_now(), bus.ADDR, bus.RSP_DATA} !== 72'd0) begin
         n_fail++;
         $display("FAIL abort async drop: got ctrl=%b addr=0x%08h rsp=0x%08h, expected all zero",
                  ctrl_now(), bus.ADDR, bus.RSP_DATA);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         n_checks++;
         if ({ctrl_now(), bus.ADDR} !== {8'h80, 32'd0}) begin
            n_fail++;
            $display("FAIL abort after release cycle %0d: got ctrl=%b addr=0x%08h, expected ctrl=10000000 addr=0",
                     i, ctrl_now(), bus.ADDR);
         end
      end
      @(posedge clk);
      #1;
      $display("reset during 8-word read done");
   endtask

   initial begin
      rst           = 1'b1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_WRITE = 1'b0;
      bus.REQ_ADDR  = 32'd0;
      bus.REQ_LEN   = 4'd0;
      bus.WR_VALID  = 1'b0;
      bus.WR_DATA   = 32'd0;
      test_reset();
      test_write_burst();
      test_read_back();
      test_write_gaps();
      test_rejects();
      test_preload();
      test_boundary();
      test_random();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
